pix_i2c_init_seq: RTL and testbench
===================================

Name: pix_i2c_init_seq

Overview:
Table-driven sequencer that sits directly upstream of the pixel-sensor I2C master and feeds its command interface. On a start pulse it walks a synchronous register-init table, issuing one write command per entry and honouring inline delay entries. It retries each failed transaction, then either completes the table or aborts with the failing index. The sensor bring-up logic uses it in place of a hand-written command state machine.

Parameters:
SlaveAddr, 7'h10, 7-bit sensor I2C address driven on every command
EntryCount, 64, table depth; walk ends after index EntryCount-1 at the latest
MaxRetries, 3, extra attempts per entry after the first failure
DelayUnitCycles, 48000, clk cycles per delay unit (1 ms at 48 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a walk from index 0
busy  out  1  high from the cycle after an accepted start until done/abort
done  out  1  single-cycle pulse at walk completion (success or abort)
err  out  1  sticky: last walk aborted; cleared by the next accepted start
err_idx  out  $clog2(EntryCount)  index of the entry that aborted the walk
tbl_addr  out  $clog2(EntryCount)  table read address
tbl_data  in  34  entry, valid 1 cycle after tbl_addr: [33]=dataLen, [32]=delay flag, [31:16]=regAddr, [15:0]=data or delay count
cmd_slaveAddr  out  7  to master
cmd_write  out  1  to master; always 1
cmd_regAddr  out  16  to master
cmd_writeData  out  16  to master
cmd_dataLen  out  1  to master; 0 = 1 byte (data[7:0]), 1 = 2 bytes
cmd_trigger  out  1  toggle; each edge launches one master command
status_done  in  1  toggle from master; each edge marks one command complete
status_err  in  1  master error flag; valid when a status_done edge is seen

Behaviour:
- Reset values: busy=0, done=0, err=0, err_idx=0, tbl_addr=0, cmd_slaveAddr=SlaveAddr, cmd_write=1, cmd_regAddr=0, cmd_writeData=0, cmd_dataLen=0, cmd_trigger=0. State=IDLE, retry counter=0, delay counter=0.
- doneSeen register: loads status_done every cycle while in IDLE, so stray edges in IDLE are ignored. An edge is detected when status_done != doneSeen.
- IDLE: on start, clear err, set tbl_addr=0 and busy=1 on the next cycle, and go to FETCH. start while busy is ignored.
- FETCH: wait 1 cycle for ROM latency, then go to DECODE.
- DECODE: latch tbl_data.
  - Delay flag=1 with count 0 is the end marker: go to FINISH with no error.
  - Delay flag=1 with count nonzero: load counter = count*DelayUnitCycles (32-bit; count 0xFFFF must not overflow) and go to DELAY.
  - Otherwise go to ISSUE.
- ISSUE: drive cmd_regAddr, cmd_writeData, cmd_dataLen and toggle cmd_trigger in the same cycle, then go to WAIT. cmd_* fields stay stable until the status_done edge.
- WAIT: on a status_done edge, update doneSeen.
  - status_err=0: clear the retry counter and go to NEXT.
  - status_err=1 and retries < MaxRetries: increment retries and return to ISSUE (re-toggle).
  - status_err=1 and retries == MaxRetries: set err=1, err_idx=tbl_addr, and go to FINISH.
- DELAY: decrement the counter each cycle; at 1, go to NEXT. Exact wait is count*DelayUnitCycles cycles in DELAY.
- NEXT: if tbl_addr == EntryCount-1, go to FINISH; else increment tbl_addr and go to FETCH. No wrap-around.
- FINISH: done=1 for 1 cycle, busy=0 on the same cycle, go to IDLE. start on the FINISH cycle is ignored.
- Minimum per-write overhead: FETCH, DECODE, ISSUE, and one cycle after the edge (NEXT), plus master latency.
- Asynchronous reset mid-walk returns to IDLE immediately. Only one master command is outstanding at any time.

Test Plan:
- Table {0x3000=0x1234 len1, 0x3002=0x56 len0, end marker}, start, master model acks with no error -> two trigger toggles carrying exactly those fields (second with cmd_dataLen=0), then done pulse, err=0, busy high throughout.
- Entry 1 is delay count 2 with DelayUnitCycles=10 -> exactly 20 cycles in DELAY between the first status_done edge and the second trigger toggle.
- Master returns status_err on entry 2 twice, then succeeds (MaxRetries=3) -> 3 toggles for entry 2, walk completes, err=0.
- Master returns status_err on every attempt for entry 1 -> 4 toggles, then done with err=1, err_idx=1, and no further toggles.
- Full table with no end marker, EntryCount=4 -> 4 commands, done after index 3, tbl_addr does not wrap. A start pulse mid-walk is ignored.
- Assert rst_n low in WAIT, toggle status_done while IDLE, then start -> outputs at reset values, the stray edge is ignored, and the new walk begins cleanly at index 0.

Source files
------------

// File: rtl/pix_i2c_init_seq.sv
// Table-driven register-init sequencer feeding the pixel-sensor I2C master.
// Walks a synchronous ROM, issues one write per entry, honours delay entries and retries failures.
module pix_i2c_init_seq #(
  parameter logic [6:0] SlaveAddr       = 7'h10,
  parameter int         EntryCount      = 64,
  parameter int         MaxRetries      = 3,
  parameter int         DelayUnitCycles = 48000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(EntryCount)-1:0] err_idx,
  output logic [$clog2(EntryCount)-1:0] tbl_addr,
  input  logic [33:0]                   tbl_data,
  output logic [6:0]                    cmd_slaveAddr,
  output logic                          cmd_write,
  output logic [15:0]                   cmd_regAddr,
  output logic [15:0]                   cmd_writeData,
  output logic                          cmd_dataLen,
  output logic                          cmd_trigger,
  input  logic                          status_done,
  input  logic                          status_err
);

  localparam int AW = $clog2(EntryCount);
  localparam int RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam logic [RW-1:0] MAX_RETRY = RW'(MaxRetries);
  localparam logic [AW-1:0] LAST_IDX  = AW'(EntryCount - 1);
  localparam logic [31:0]   DLY_UNIT  = 32'(DelayUnitCycles);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, NEXT, FINISH
  } state_t;

  state_t          r_state, w_state;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_err, w_err;
  logic [AW-1:0]   r_err_idx, w_err_idx;
  logic [AW-1:0]   r_tbl_addr, w_tbl_addr;
  logic [15:0]     r_reg_addr, w_reg_addr;
  logic [15:0]     r_wdata, w_wdata;
  logic            r_len, w_len;
  logic            r_trig, w_trig;
  logic            r_done_seen, w_done_seen;
  logic [RW-1:0]   r_retry, w_retry;
  logic [31:0]     r_dly_cnt, w_dly_cnt;
  logic [32:0]     r_entry, w_entry;   // {dataLen, regAddr, data}
  logic            w_edge;
  logic [31:0]     w_dly_load;

  assign w_edge     = (status_done != r_done_seen);
  // 16-bit count times a 32-bit unit; the product fits 32 bits for the full count range.
  assign w_dly_load = 32'(tbl_data[15:0]) * DLY_UNIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_idx   <= '0;
      r_tbl_addr  <= '0;
      r_reg_addr  <= '0;
      r_wdata     <= '0;
      r_len       <= 1'b0;
      r_trig      <= 1'b0;
      r_done_seen <= 1'b0;
      r_retry     <= '0;
      r_dly_cnt   <= '0;
      r_entry     <= '0;
    end else begin
      r_state     <= w_state;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
      r_err_idx   <= w_err_idx;
      r_tbl_addr  <= w_tbl_addr;
      r_reg_addr  <= w_reg_addr;
      r_wdata     <= w_wdata;
      r_len       <= w_len;
      r_trig      <= w_trig;
      r_done_seen <= w_done_seen;
      r_retry     <= w_retry;
      r_dly_cnt   <= w_dly_cnt;
      r_entry     <= w_entry;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_err       = r_err;
    w_err_idx   = r_err_idx;
    w_tbl_addr  = r_tbl_addr;
    w_reg_addr  = r_reg_addr;
    w_wdata     = r_wdata;
    w_len       = r_len;
    w_trig      = r_trig;
    w_done_seen = r_done_seen;
    w_retry     = r_retry;
    w_dly_cnt   = r_dly_cnt;
    w_entry     = r_entry;
    case (r_state)
      IDLE: begin
        // Track the master toggle so edges arriving while idle never count.
        w_done_seen = status_done;
        if (start) begin
          w_err      = 1'b0;
          w_tbl_addr = '0;
          w_busy     = 1'b1;
          w_retry    = '0;
          w_state    = FETCH;
        end
      end
      FETCH: w_state = DECODE;
      DECODE: begin
        w_entry = {tbl_data[33], tbl_data[31:0]};
        if (tbl_data[32]) begin
          if (tbl_data[15:0] == 16'd0) begin
            w_state = FINISH;
          end else begin
            w_dly_cnt = w_dly_load;
            w_state   = DELAY;
          end
        end else begin
          w_state = ISSUE;
        end
      end
      ISSUE: begin
        w_reg_addr = r_entry[31:16];
        w_wdata    = r_entry[15:0];
        w_len      = r_entry[32];
        w_trig     = ~r_trig;
        w_state    = WAIT;
      end
      WAIT: begin
        if (w_edge) begin
          w_done_seen = status_done;
          if (!status_err) begin
            w_retry = '0;
            w_state = NEXT;
          end else if (r_retry < MAX_RETRY) begin
            w_retry = r_retry + RW'(1);
            w_state = ISSUE;
          end else begin
            w_err     = 1'b1;
            w_err_idx = r_tbl_addr;
            w_state   = FINISH;
          end
        end
      end
      DELAY: begin
        w_dly_cnt = r_dly_cnt - 32'd1;
        if (r_dly_cnt <= 32'd1) w_state = NEXT;
      end
      NEXT: begin
        if (r_tbl_addr == LAST_IDX) begin
          w_state = FINISH;
        end else begin
          w_tbl_addr = r_tbl_addr + AW'(1);
          w_state    = FETCH;
        end
      end
      FINISH: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign err_idx       = r_err_idx;
  assign tbl_addr      = r_tbl_addr;
  assign cmd_slaveAddr = SlaveAddr;
  assign cmd_write     = 1'b1;
  assign cmd_regAddr   = r_reg_addr;
  assign cmd_writeData = r_wdata;
  assign cmd_dataLen   = r_len;
  assign cmd_trigger   = r_trig;

endmodule

// File: tb/tb_pix_i2c_init_seq.sv
// Scoreboard bench for pix_i2c_init_seq: ROM model, toggle-handshake master model, expected-command queue.
module tb_pix_i2c_init_seq;

  localparam int         ENTRIES = 4;
  localparam int         RETRIES = 3;
  localparam int         DLY     = 10;
  localparam int         LAT     = 3;
  localparam logic [6:0] SADDR   = 7'h10;
  localparam logic [63:0] RESET_PACK = 64'({3'b000, 2'd0, 2'd0, SADDR, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0});

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_idx, tbl_addr;
  logic [33:0] tbl_data = '0;
  logic [6:0]  cmd_slaveAddr;
  logic        cmd_write;
  logic [15:0] cmd_regAddr, cmd_writeData;
  logic        cmd_dataLen, cmd_trigger;
  logic        status_done = 1'b0;
  logic        status_err = 1'b0;

  always #5 clk = ~clk;

  pix_i2c_init_seq #(
    .SlaveAddr(SADDR), .EntryCount(ENTRIES), .MaxRetries(RETRIES), .DelayUnitCycles(DLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .err_idx(err_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cmd_slaveAddr(cmd_slaveAddr), .cmd_write(cmd_write), .cmd_regAddr(cmd_regAddr),
    .cmd_writeData(cmd_writeData), .cmd_dataLen(cmd_dataLen), .cmd_trigger(cmd_trigger),
    .status_done(status_done), .status_err(status_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [40:0] pack_cmd(input logic [15:0] ra, input logic [15:0] d, input logic l);
    return {SADDR, 1'b1, ra, d, l};
  endfunction

  function automatic logic [40:0] dut_cmd();
    return {cmd_slaveAddr, cmd_write, cmd_regAddr, cmd_writeData, cmd_dataLen};
  endfunction

  function automatic logic [63:0] out_pack();
    return 64'({busy, done, err, err_idx, tbl_addr, cmd_slaveAddr, cmd_write,
                cmd_regAddr, cmd_writeData, cmd_dataLen, cmd_trigger});
  endfunction

  logic [33:0] tbl [ENTRIES];
  int          fail_plan [ENTRIES];
  logic [40:0] sb_q [$];
  int          trig_cyc [$];
  int          resp_cyc [$];
  int          n_trig = 0;
  int          n_resp = 0;
  int          n_resets = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data follows the address one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      tbl_data = tbl[tbl_addr];
    end
  end

  // Master model: pops the scoreboard on each trigger edge and answers after LAT cycles.
  initial begin
    logic        last_trig;
    logic [40:0] seen, exp;
    int          idx, rst_mark;
    logic        e;
    last_trig = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_trig = cmd_trigger;
        continue;
      end
      if (cmd_trigger != last_trig) begin
        last_trig = cmd_trigger;
        check_val("one_outstanding", 64'(n_trig), 64'(n_resp));
        n_trig++;
        trig_cyc.push_back(cyc);
        seen = dut_cmd();
        exp  = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        check_val("cmd_fields", 64'(seen), 64'(exp));
        idx      = int'(tbl_addr);
        rst_mark = n_resets;
        repeat (LAT) @(negedge clk);
        if (rst_mark == n_resets) begin
          check_val("cmd_stable", 64'(dut_cmd()), 64'(seen));
        end else begin
          last_trig = cmd_trigger;
        end
        e = (fail_plan[idx] > 0);
        if (e) fail_plan[idx]--;
        status_err  = e;
        status_done = ~status_done;
        n_resp++;
        resp_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [33:0] wr(input logic [15:0] ra, input logic [15:0] d, input logic l);
    return {l, 1'b0, ra, d};
  endfunction

  function automatic logic [33:0] dl(input logic [15:0] cnt);
    return {1'b0, 1'b1, 16'h0000, cnt};
  endfunction

  task automatic run_walk(input string name, input bit mid_start);
    bit ex_err;
    int ex_idx, ex_addr, ex_cmds, att, trig0, busy_low;
    bit got_done;
    ex_err = 0; ex_idx = 0; ex_cmds = 0; ex_addr = ENTRIES - 1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (tbl[i][32]) begin
        if (tbl[i][15:0] == 16'd0) begin
          ex_addr = i;
          break;
        end
        continue;
      end
      att = (fail_plan[i] > RETRIES) ? RETRIES + 1 : fail_plan[i] + 1;
      for (int a = 0; a < att; a++) sb_q.push_back(pack_cmd(tbl[i][31:16], tbl[i][15:0], tbl[i][33]));
      ex_cmds += att;
      if (fail_plan[i] > RETRIES) begin
        ex_err = 1; ex_idx = i; ex_addr = i;
        break;
      end
    end
    trig0 = n_trig;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got_done = 0; busy_low = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        got_done = 1;
        break;
      end
      if (!busy) busy_low++;
      start = (mid_start && k == 10);
      @(negedge clk);
    end
    start = 1'b0;
    check_val({name, "_done"}, 64'(got_done), 64'd1);
    check_val({name, "_busy_held"}, 64'(busy_low), 64'd0);
    check_val({name, "_busy_at_done"}, 64'(busy), 64'd0);
    check_val({name, "_err"}, 64'(err), 64'(ex_err));
    if (ex_err) check_val({name, "_err_idx"}, 64'(err_idx), 64'(ex_idx));
    check_val({name, "_last_addr"}, 64'(tbl_addr), 64'(ex_addr));
    @(negedge clk);
    check_val({name, "_done_pulse"}, 64'(done), 64'd0);
    repeat (10) @(negedge clk);
    check_val({name, "_cmd_count"}, 64'(n_trig - trig0), 64'(ex_cmds));
    check_val({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < ENTRIES; i++) begin
      fail_plan[i] = 0;
      tbl[i] = dl(16'd0);
    end
  endtask

  initial begin
    int  t0;
    bit  seen_trig;
    clear_plan();
    repeat (3) @(negedge clk);
    check_val("reset_vals", out_pack(), RESET_PACK);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two writes then end marker.
    clear_plan();
    tbl[0] = wr(16'h3000, 16'h1234, 1'b1);
    tbl[1] = wr(16'h3002, 16'h0056, 1'b0);
    run_walk("basic", 0);

    // Inline delay of 2 units between two writes.
    clear_plan();
    tbl[0] = wr(16'h3010, 16'h00AA, 1'b0);
    tbl[1] = dl(16'd2);
    tbl[2] = wr(16'h3012, 16'hBEEF, 1'b1);
    t0 = trig_cyc.size();
    run_walk("delay", 0);
    // Edge seen -> NEXT, FETCH, DECODE, delay cycles, NEXT, FETCH, DECODE, ISSUE, then visible.
    if (trig_cyc.size() >= t0 + 2 && resp_cyc.size() > t0)
      check_val("delay_gap", 64'(trig_cyc[t0 + 1] - resp_cyc[t0]), 64'(2 * DLY + 8));
    else
      check_val("delay_gap_present", 64'(trig_cyc.size()), 64'(t0 + 2));

    // Entry 2 fails twice then succeeds.
    clear_plan();
    tbl[0] = wr(16'h3020, 16'h0001, 1'b0);
    tbl[1] = wr(16'h3021, 16'h0002, 1'b0);
    tbl[2] = wr(16'h3022, 16'h0003, 1'b1);
    fail_plan[2] = 2;
    run_walk("retry_ok", 0);

    // Entry 1 fails every attempt: abort.
    clear_plan();
    tbl[0] = wr(16'h3030, 16'h0011, 1'b0);
    tbl[1] = wr(16'h3031, 16'h0022, 1'b0);
    tbl[2] = wr(16'h3032, 16'h0033, 1'b0);
    fail_plan[1] = 100;
    run_walk("abort", 0);

    // Full table, no end marker, stray start mid-walk.
    clear_plan();
    for (int i = 0; i < ENTRIES; i++) tbl[i] = wr(16'h3040 + 16'(i), 16'hA500 + 16'(i), 1'(i));
    run_walk("full", 1);
    check_val("full_err_cleared_flag", 64'(err), 64'd0);

    // Reset while waiting on the master, stray edge in IDLE, then a clean walk.
    clear_plan();
    tbl[0] = wr(16'h3100, 16'h0077, 1'b1);
    sb_q.push_back(pack_cmd(16'h3100, 16'h0077, 1'b1));
    t0 = n_trig;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen_trig = 0;
    for (int k = 0; k < 100; k++) begin
      if (n_trig > t0) begin
        seen_trig = 1;
        break;
      end
      @(negedge clk);
    end
    check_val("rst_first_trig", 64'(seen_trig), 64'd1);
    #1 rst_n = 1'b0;
    n_resets++;
    @(negedge clk);
    check_val("rst_mid_walk_vals", out_pack(), RESET_PACK);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_val("stray_edge_sent", 64'(n_resp), 64'(n_trig));
    check_val("idle_after_stray", 64'({busy, tbl_addr, cmd_trigger}), 64'd0);
    tbl[0] = wr(16'h3200, 16'h0099, 1'b0);
    run_walk("post_reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
